apu_req_master: RTL and testbench
=================================

APU_REQ_MASTER -- requirements
Module: apu_req_master

Interface
REQ-001 Parameter ID_WIDTH, default 9, tag width carried on apu_ID_o / apu_rID_i.
REQ-002 Parameter NB_ARGS, default 2, number of operands per request.
REQ-003 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-004 Parameter OPCODE_WIDTH, default 6, opcode width ({vec_op, op_mod, op}).
REQ-005 Parameter FLAGS_IN_WIDTH, default 15, request flags width ({int_fmt, src_fmt, dst_fmt, rnd_mode}).
REQ-006 Parameter FLAGS_OUT_WIDTH, default 5, response status flags width.
REQ-007 Parameter MAX_OUTSTANDING, default 4, power of two >= 2; request credit limit and response FIFO depth.
REQ-008 The clock is clk, a single clock; the reset is rst_n, asynchronous and active-low.
REQ-009 Core request ports: core_req_i in 1, core_gnt_o out 1, core_tag_i in ID_WIDTH, core_operands_i in NB_ARGS x DATA_WIDTH, core_op_i in OPCODE_WIDTH, core_flags_i in FLAGS_IN_WIDTH.
REQ-010 Core response ports: core_rvalid_o out 1, core_rready_i in 1, core_rdata_o out DATA_WIDTH, core_rflags_o out FLAGS_OUT_WIDTH, core_rtag_o out ID_WIDTH.
REQ-011 APU request ports: apu_req_o out 1, apu_gnt_i in 1, apu_ID_o out ID_WIDTH, apu_operands_o out NB_ARGS x DATA_WIDTH, apu_op_o out OPCODE_WIDTH, apu_flags_o out FLAGS_IN_WIDTH.
REQ-012 APU response ports: apu_rready_o out 1, apu_rvalid_i in 1, apu_rdata_i in DATA_WIDTH, apu_rflags_i in FLAGS_OUT_WIDTH, apu_rID_i in ID_WIDTH.
REQ-013 Status: err_o out 1, sticky protocol error; occ_o out clog2(MAX_OUTSTANDING)+1, current occupancy.

Function
REQ-014 Request FSM states: IDLE (holding register empty) and REQ (holding register valid, apu_req_o=1).
REQ-015 core_gnt_o=1 iff occ < MAX_OUTSTANDING and (state==IDLE or (state==REQ and apu_gnt_i)); core_gnt_o=1 with core_req_i=1 is a core handshake.
REQ-016 On a core handshake, the holding register captures tag, operands, op and flags, and the state is REQ next cycle.
REQ-017 In REQ, apu_req_o=1 and apu_ID_o/apu_operands_o/apu_op_o/apu_flags_o remain stable until the cycle apu_gnt_i=1.
REQ-018 On REQ with apu_gnt_i=1 and no new core handshake, the next state is IDLE; with a new core handshake, the state stays REQ with the new contents (back-to-back, 1 request/cycle).
REQ-019 occ counts accepted core requests whose response has not been popped to the core; +1 on core handshake, -1 on core response pop; both in the same cycle leave occ unchanged.
REQ-020 inflight counts APU-granted requests without a response; +1 on apu_req_o&apu_gnt_i, -1 on apu_rvalid_i.
REQ-021 apu_rready_o=1 in every cycle out of reset; responses are never back-pressured.
REQ-022 Each apu_rvalid_i with inflight>0 pushes {rdata, rflags, rID} into the response FIFO, in arrival order, with no reordering by ID.
REQ-023 core_rvalid_o=1 iff the FIFO is non-empty; the head is popped when core_rvalid_o&core_rready_i, and core_rdata_o/rflags_o/rtag_o hold stable while stalled.
REQ-024 Latency: apu_rvalid_i in cycle N gives core_rvalid_o in cycle N+1 (no bypass when empty); grant path: core handshake in cycle N gives apu_req_o in cycle N+1.
REQ-025 The FIFO cannot overflow because of the occ bound; push and pop in the same cycle are both honoured at any fill level; pointers wrap modulo MAX_OUTSTANDING.
REQ-026 apu_rvalid_i with inflight==0 is dropped (no push, counters unchanged) and sets err_o=1 until reset.

Reset
REQ-027 While rst_n=0: state=IDLE; occ, inflight and FIFO pointers are 0; all outputs are 0, including apu_rready_o, core_gnt_o and err_o.
REQ-028 Reset asserted mid-transaction discards the held request and all buffered responses; apu_req_o drops asynchronously.

Structure
REQ-029 Package apu_master_pkg holds the FSM state enum (IDLE, REQ) and the width helper for occ.
REQ-030 The response buffer is sub-module apu_resp_fifo (parametric width and depth, push/pop, full/empty), instantiated once.

Verification
REQ-031 Single op: core_req with tag 0x05 and operands {0x3F800000, 0x40000000}; apu_gnt_i after 2 cycles -> apu_ID_o=0x05 stable for 3 cycles; rvalid with 0x40400000 -> core_rvalid_o next cycle, rdata=0x40400000, rtag=0x05.
REQ-032 Credit limit: 5 back-to-back requests, apu_gnt_i=1, no responses, core_rready_i=0 -> 4 accepted, core_gnt_o=0 on the 5th, occ_o=4.
REQ-033 Core stall: 4 responses arrive with core_rready_i=0 -> no loss; then core_rready_i=1 -> 4 pops in arrival order on consecutive cycles.
REQ-034 Simultaneous events: FIFO at 3 entries with push and pop in the same cycle -> FIFO stays at 3; occ unchanged with a handshake and pop in the same cycle.
REQ-035 Stray response: apu_rvalid_i=1 with inflight=0 -> err_o=1, core_rvalid_o stays 0, err_o held until rst_n=0.
REQ-036 Reset mid-operation: rst_n low with occ=3 and REQ pending -> all outputs 0 immediately; after release, occ_o=0, apu_rready_o=1.

Source files
------------

// File: rtl/apu_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apu_master_pkg : shared types and width helper for the APU request master |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package apu_master_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } req_state_e;

    // Occupancy must be able to represent the full credit count itself.
    function automatic int occ_width(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_resp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apu_resp_fifo : power-of-two depth response FIFO, head exposed combinat.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module apu_resp_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int              c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full_count = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o     = (r_count == c_full_count);
    assign empty_o    = (r_count == '0);
    assign w_pop      = pop_i & ~empty_o;
    // A pop frees the slot this cycle, so a push into a full FIFO is honoured.
    assign w_push     = push_i & (~full_o | w_pop);
    assign pop_data_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/apu_req_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apu_req_master : credit-limited core-to-APU request bridge, in-order resp |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module apu_req_master
    import apu_master_pkg::*;
#(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                core_req_i,
    output logic                                core_gnt_o,
    input  logic [ID_WIDTH-1:0]                 core_tag_i,
    input  logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  core_operands_i,
    input  logic [OPCODE_WIDTH-1:0]             core_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]           core_flags_i,

    output logic                                core_rvalid_o,
    input  logic                                core_rready_i,
    output logic [DATA_WIDTH-1:0]               core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]          core_rflags_o,
    output logic [ID_WIDTH-1:0]                 core_rtag_o,

    output logic                                apu_req_o,
    input  logic                                apu_gnt_i,
    output logic [ID_WIDTH-1:0]                 apu_ID_o,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  apu_operands_o,
    output logic [OPCODE_WIDTH-1:0]             apu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]           apu_flags_o,

    output logic                                apu_rready_o,
    input  logic                                apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               apu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]          apu_rflags_i,
    input  logic [ID_WIDTH-1:0]                 apu_rID_i,

    output logic                                err_o,
    output logic [$clog2(MAX_OUTSTANDING):0]    occ_o
);

    localparam int                   c_occ_w   = occ_width(MAX_OUTSTANDING);
    localparam int                   c_rsp_w   = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;
    localparam logic [c_occ_w-1:0]   c_max_occ = c_occ_w'(MAX_OUTSTANDING);

    req_state_e                          r_state;
    logic [ID_WIDTH-1:0]                 r_tag;
    logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  r_operands;
    logic [OPCODE_WIDTH-1:0]             r_op;
    logic [FLAGS_IN_WIDTH-1:0]           r_flags;
    logic [c_occ_w-1:0]                  r_occ;
    logic [c_occ_w-1:0]                  r_inflight;
    logic                                r_err;

    logic                                w_core_hs;
    logic                                w_apu_hs;
    logic                                w_rsp_push;
    logic                                w_stray;
    logic                                w_pop;
    logic                                w_fifo_full;
    logic                                w_fifo_empty;
    logic [c_rsp_w-1:0]                  w_rsp_head;

    // rst_n gates the combinational outputs so every output is 0 during reset.
    assign core_gnt_o   = rst_n & (r_occ < c_max_occ) & ((r_state == IDLE) | apu_gnt_i);
    assign apu_rready_o = rst_n;

    assign w_core_hs  = core_req_i & core_gnt_o;
    assign w_apu_hs   = apu_req_o & apu_gnt_i;
    assign w_stray    = apu_rvalid_i & (r_inflight == '0);
    assign w_rsp_push = apu_rvalid_i & (r_inflight != '0);
    assign w_pop      = core_rvalid_o & core_rready_i;

    assign apu_req_o      = (r_state == REQ);
    assign apu_ID_o       = r_tag;
    assign apu_operands_o = r_operands;
    assign apu_op_o       = r_op;
    assign apu_flags_o    = r_flags;
    assign occ_o          = r_occ;
    assign err_o          = r_err;

    assign core_rvalid_o = ~w_fifo_empty;
    assign {core_rdata_o, core_rflags_o, core_rtag_o} = w_fifo_empty ? '0 : w_rsp_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tag      <= '0;
            r_operands <= '0;
            r_op       <= '0;
            r_flags    <= '0;
        end else if (w_core_hs) begin
            // Also covers the back-to-back case: grant and refill in one cycle.
            r_state    <= REQ;
            r_tag      <= core_tag_i;
            r_operands <= core_operands_i;
            r_op       <= core_op_i;
            r_flags    <= core_flags_i;
        end else if (w_apu_hs) begin
            r_state    <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            case ({w_core_hs, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            case ({w_apu_hs, w_rsp_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            r_err <= r_err | w_stray;
        end
    end

    apu_resp_fifo #(
        .WIDTH (c_rsp_w),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_rsp_push),
        .push_data_i ({apu_rdata_i, apu_rflags_i, apu_rID_i}),
        .pop_i       (w_pop),
        .pop_data_o  (w_rsp_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    // Overflow is excluded by the credit bound; full is kept for visibility.
    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_apu_req_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apu_req_master : directed scenarios plus randomized model comparison   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_apu_req_master;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_req_i;
    logic              core_gnt_o;
    logic [8:0]        core_tag_i;
    logic [1:0][31:0]  core_operands_i;
    logic [5:0]        core_op_i;
    logic [14:0]       core_flags_i;
    logic              core_rvalid_o;
    logic              core_rready_i;
    logic [31:0]       core_rdata_o;
    logic [4:0]        core_rflags_o;
    logic [8:0]        core_rtag_o;
    logic              apu_req_o;
    logic              apu_gnt_i;
    logic [8:0]        apu_ID_o;
    logic [1:0][31:0]  apu_operands_o;
    logic [5:0]        apu_op_o;
    logic [14:0]       apu_flags_o;
    logic              apu_rready_o;
    logic              apu_rvalid_i;
    logic [31:0]       apu_rdata_i;
    logic [4:0]        apu_rflags_i;
    logic [8:0]        apu_rID_i;
    logic              err_o;
    logic [2:0]        occ_o;

    int n_tests = 0;
    int n_fail  = 0;

    apu_req_master dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_tag_i(core_tag_i),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
        .core_rvalid_o(core_rvalid_o), .core_rready_i(core_rready_i), .core_rdata_o(core_rdata_o),
        .core_rflags_o(core_rflags_o), .core_rtag_o(core_rtag_o),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_ID_o(apu_ID_o),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rready_o(apu_rready_o), .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i),
        .apu_rflags_i(apu_rflags_i), .apu_rID_i(apu_rID_i),
        .err_o(err_o), .occ_o(occ_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_i = 0; core_tag_i = '0; core_operands_i = '0; core_op_i = '0; core_flags_i = '0;
        core_rready_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0; apu_rdata_i = '0;
        apu_rflags_i = '0; apu_rID_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();
    endtask

    // Four requests accepted and granted, no responses yet: occ=4, inflight=4.
    task automatic fill_four();
        apu_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            core_req_i = 1; core_tag_i = 9'(i);
            tick();
        end
        core_req_i = 0;
        tick();
        apu_gnt_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        core_req_i = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (core_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", core_gnt_o); end
        n_tests++; if (apu_rready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", apu_rready_o); end
        n_tests++; if ({apu_req_o, core_rvalid_o, err_o, occ_o} !== 6'b0) begin n_fail++;
            $display("FAIL reset_outs: got req=%b rvalid=%b err=%b occ=%0d want all 0", apu_req_o, core_rvalid_o, err_o, occ_o); end
        core_req_i = 0;
        rst_n = 1;
        #1;
        n_tests++; if (apu_rready_o !== 1'b1) begin n_fail++; $display("FAIL release_rready: got %b want 1", apu_rready_o); end
        n_tests++; if (core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL release_gnt: got %b want 1", core_gnt_o); end
        tick();
    endtask

    task automatic test_single_op();
        logic [1:0][31:0] ops;
        ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000;
        do_reset();
        core_req_i = 1; core_tag_i = 9'h005; core_operands_i = ops; core_op_i = 6'h0A; core_flags_i = 15'h0123;
        #1;
        n_tests++; if (core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", core_gnt_o); end
        tick();
        core_req_i = 0;
        for (int k = 0; k < 3; k++) begin
            apu_gnt_i = (k == 2);
            #1;
            n_tests++;
            if ({apu_req_o, apu_ID_o, apu_operands_o, apu_op_o, apu_flags_o} !== {1'b1, 9'h005, ops, 6'h0A, 15'h0123}) begin
                n_fail++; $display("FAIL single_hold%0d: got req=%b id=%h ops=%h want req=1 id=005 ops=%h", k, apu_req_o, apu_ID_o, apu_operands_o, ops);
            end
            if (k == 0) begin
                n_tests++; if (core_gnt_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_gnt: got %b want 0", core_gnt_o); end
            end
            tick();
        end
        apu_gnt_i = 0;
        n_tests++; if (apu_req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b want 0", apu_req_o); end
        apu_rvalid_i = 1; apu_rdata_i = 32'h4040_0000; apu_rflags_i = 5'h01; apu_rID_i = 9'h005;
        #1;
        n_tests++; if (core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", core_rvalid_o); end
        tick();
        apu_rvalid_i = 0;
        n_tests++;
        if ({core_rvalid_o, core_rdata_o, core_rflags_o, core_rtag_o} !== {1'b1, 32'h4040_0000, 5'h01, 9'h005}) begin
            n_fail++; $display("FAIL single_resp: got v=%b d=%h f=%h t=%h want v=1 d=40400000 f=01 t=005", core_rvalid_o, core_rdata_o, core_rflags_o, core_rtag_o);
        end
        n_tests++; if (occ_o !== 3'd1) begin n_fail++; $display("FAIL single_occ: got %0d want 1", occ_o); end
        core_rready_i = 1;
        tick();
        core_rready_i = 0;
        n_tests++; if ({core_rvalid_o, occ_o} !== 4'b0) begin n_fail++; $display("FAIL single_pop: got v=%b occ=%0d want 0/0", core_rvalid_o, occ_o); end
    endtask

    task automatic test_credit_limit();
        do_reset();
        apu_gnt_i = 1;
        for (int i = 0; i < 5; i++) begin
            core_req_i = 1; core_tag_i = 9'(i);
            #1;
            n_tests++; if (core_gnt_o !== (i < 4)) begin n_fail++; $display("FAIL credit_gnt%0d: got %b want %b", i, core_gnt_o, (i < 4)); end
            tick();
        end
        core_req_i = 0; apu_gnt_i = 0;
        n_tests++; if (occ_o !== 3'd4) begin n_fail++; $display("FAIL credit_occ: got %0d want 4", occ_o); end
        n_tests++; if (apu_req_o !== 1'b0) begin n_fail++; $display("FAIL credit_req: got %b want 0", apu_req_o); end
    endtask

    // Continues from the credit-limit state: four requests granted, none answered.
    task automatic test_core_stall();
        for (int i = 0; i < 4; i++) begin
            apu_rvalid_i = 1; apu_rdata_i = 32'hA0 + 32'(i); apu_rflags_i = 5'(i); apu_rID_i = 9'(i + 16);
            tick();
        end
        apu_rvalid_i = 0;
        tick();
        n_tests++; if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hA0}) begin n_fail++; $display("FAIL stall_head: got v=%b d=%h want 1/a0", core_rvalid_o, core_rdata_o); end
        n_tests++; if (occ_o !== 3'd4) begin n_fail++; $display("FAIL stall_occ: got %0d want 4", occ_o); end
        core_rready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({core_rvalid_o, core_rdata_o, core_rflags_o, core_rtag_o} !== {1'b1, 32'hA0 + 32'(i), 5'(i), 9'(i + 16)}) begin
                n_fail++; $display("FAIL stall_pop%0d: got v=%b d=%h t=%h want d=%h", i, core_rvalid_o, core_rdata_o, core_rtag_o, 32'hA0 + 32'(i));
            end
            tick();
        end
        core_rready_i = 0;
        n_tests++; if ({core_rvalid_o, occ_o} !== 4'b0) begin n_fail++; $display("FAIL stall_drain: got v=%b occ=%0d want 0/0", core_rvalid_o, occ_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fill_four();
        for (int i = 0; i < 3; i++) begin
            apu_rvalid_i = 1; apu_rdata_i = 32'hB0 + 32'(i);
            tick();
        end
        // FIFO holds 3: push the 4th while popping the head.
        apu_rdata_i = 32'hB3; core_rready_i = 1;
        tick();
        apu_rvalid_i = 0;
        n_tests++; if (occ_o !== 3'd3) begin n_fail++; $display("FAIL simul_occ_pop: got %0d want 3", occ_o); end
        n_tests++; if (core_rdata_o !== 32'hB1) begin n_fail++; $display("FAIL simul_head: got %h want b1", core_rdata_o); end
        core_req_i = 1; core_tag_i = 9'h01F;
        #1;
        n_tests++; if (core_gnt_o !== 1'b1) begin n_fail++; $display("FAIL simul_gnt: got %b want 1", core_gnt_o); end
        tick();
        core_req_i = 0;
        n_tests++; if (occ_o !== 3'd3) begin n_fail++; $display("FAIL simul_occ_hs_pop: got %0d want 3", occ_o); end
        for (int i = 2; i < 4; i++) begin
            #1;
            n_tests++; if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hB0 + 32'(i)}) begin n_fail++;
                $display("FAIL simul_drain%0d: got v=%b d=%h want 1/%h", i, core_rvalid_o, core_rdata_o, 32'hB0 + 32'(i)); end
            tick();
        end
        core_rready_i = 0;
        n_tests++; if ({core_rvalid_o, occ_o} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL simul_end: got v=%b occ=%0d want 0/1", core_rvalid_o, occ_o); end
    endtask

    task automatic test_stray();
        do_reset();
        apu_rvalid_i = 1; apu_rdata_i = 32'hDEAD_BEEF; apu_rID_i = 9'h0AA;
        tick();
        apu_rvalid_i = 0;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL stray_err: got %b want 1", err_o); end
        n_tests++; if (core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid: got %b want 0", core_rvalid_o); end
        repeat (3) tick();
        n_tests++; if ({err_o, occ_o, core_rvalid_o} !== {1'b1, 3'd0, 1'b0}) begin n_fail++;
            $display("FAIL stray_sticky: got err=%b occ=%0d v=%b want 1/0/0", err_o, occ_o, core_rvalid_o); end
        rst_n = 0;
        #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL stray_clear: got %b want 0", err_o); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        apu_gnt_i = 1;
        for (int i = 0; i < 3; i++) begin
            core_req_i = 1; core_tag_i = 9'(i + 1);
            tick();
        end
        core_req_i = 0; apu_gnt_i = 0;
        apu_rvalid_i = 1; apu_rdata_i = 32'h77;
        tick();
        apu_rvalid_i = 0;
        n_tests++; if ({apu_req_o, core_rvalid_o, occ_o} !== {1'b1, 1'b1, 3'd3}) begin n_fail++;
            $display("FAIL mid_setup: got req=%b v=%b occ=%0d want 1/1/3", apu_req_o, core_rvalid_o, occ_o); end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({apu_req_o, core_rvalid_o, occ_o, core_gnt_o, apu_rready_o, apu_ID_o, core_rdata_o} !== '0) begin
            n_fail++; $display("FAIL mid_async: got req=%b v=%b occ=%0d gnt=%b rr=%b id=%h d=%h want all 0",
                apu_req_o, core_rvalid_o, occ_o, core_gnt_o, apu_rready_o, apu_ID_o, core_rdata_o);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        n_tests++; if ({occ_o, apu_rready_o, apu_req_o, core_rvalid_o} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL mid_release: got occ=%0d rr=%b req=%b v=%b want 0/1/0/0", occ_o, apu_rready_o, apu_req_o, core_rvalid_o); end
    endtask

    // Model: a single pending request slot, a credit count, a count of granted
    // requests, and an ordered queue of responses awaiting the core.
    task automatic test_random();
        bit               m_held;
        logic [8:0]       m_tag;
        logic [1:0][31:0] m_ops;
        logic [5:0]       m_op;
        logic [14:0]      m_flags;
        int               m_occ;
        int               m_inflight;
        logic [45:0]      rq[$];
        bit               exp_gnt, hs, ahs, pop;
        do_reset();
        m_held = 0; m_occ = 0; m_inflight = 0; m_tag = '0; m_ops = '0; m_op = '0; m_flags = '0;
        for (int c = 0; c < 800; c++) begin
            core_req_i      = ($urandom_range(0, 3) != 0);
            core_tag_i      = 9'($urandom);
            core_operands_i = {$urandom, $urandom};
            core_op_i       = 6'($urandom);
            core_flags_i    = 15'($urandom);
            apu_gnt_i       = ($urandom_range(0, 2) != 0);
            apu_rvalid_i    = (m_inflight > 0) && ($urandom_range(0, 1) != 0);
            apu_rdata_i     = $urandom;
            apu_rflags_i    = 5'($urandom);
            apu_rID_i       = 9'($urandom);
            core_rready_i   = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            exp_gnt = (m_occ < 4) && (!m_held || apu_gnt_i);
            n_tests++; if (core_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, core_gnt_o, exp_gnt); end
            n_tests++; if (apu_req_o !== m_held) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, apu_req_o, m_held); end
            if (m_held) begin
                n_tests++;
                if ({apu_ID_o, apu_operands_o, apu_op_o, apu_flags_o} !== {m_tag, m_ops, m_op, m_flags}) begin
                    n_fail++; $display("FAIL rnd_hold c%0d: got id=%h ops=%h want id=%h ops=%h", c, apu_ID_o, apu_operands_o, m_tag, m_ops);
                end
            end
            n_tests++; if (core_rvalid_o !== (rq.size() > 0)) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, core_rvalid_o, rq.size() > 0); end
            if (rq.size() > 0) begin
                n_tests++;
                if ({core_rdata_o, core_rflags_o, core_rtag_o} !== rq[0]) begin
                    n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, {core_rdata_o, core_rflags_o, core_rtag_o}, rq[0]);
                end
            end
            n_tests++; if (occ_o !== 3'(m_occ)) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occ_o, m_occ); end
            n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want 0", c, err_o); end
            hs  = core_req_i && exp_gnt;
            ahs = m_held && apu_gnt_i;
            pop = (rq.size() > 0) && core_rready_i;
            if (pop) void'(rq.pop_front());
            if (apu_rvalid_i) rq.push_back({apu_rdata_i, apu_rflags_i, apu_rID_i});
            m_inflight += int'(ahs) - int'(apu_rvalid_i);
            m_occ      += int'(hs) - int'(pop);
            if (hs) begin
                m_held = 1; m_tag = core_tag_i; m_ops = core_operands_i; m_op = core_op_i; m_flags = core_flags_i;
            end else if (ahs) begin
                m_held = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_single_op();
        test_credit_limit();
        test_core_stall();
        test_simultaneous();
        test_stray();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
